// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - hazard detection and stall control for the 5-stage MIPS pipeline
//
// Detects hazards that forwarding cannot resolve (load-use, branch-in-decode
// operand dependencies, mul/div occupancy) and the data-memory wait, and drives
// the pipeline enables, the ID/EX bubble and the IF/ID flush.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   decodeRS/RT/UsesRT            source operands of the instruction in ID
//   decodeBranch                  ID holds a beq/bne compared in ID
//   decodeStartMD/ReadsHiLo       ID holds mult/div or mfhi/mflo
//   executeRD/_registerWrite/_memRead   destination info of the EX instruction
//   memoryRD/_memRead/_memAccess  destination and memory info of the MEM instruction
//   dmemReady                     data memory completes the access this cycle
//   branchTaken                   branch in ID resolved taken
//   pcWrite/ifidWrite/idexWrite/exmemWrite  pipeline register write enables
//   idexBubble, ifidFlush         NOP into ID/EX, clear IF/ID
//   mdBusy                        mul/div unit occupied
//   stallCycles                   saturating count of bubble cycles

module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       decodeRS,
  input  logic [4:0]       decodeRT,
  input  logic             decodeUsesRT,
  input  logic             decodeBranch,
  input  logic             decodeStartMD,
  input  logic             decodeReadsHiLo,
  input  logic [4:0]       executeRD,
  input  logic             execute_registerWrite,
  input  logic             execute_memRead,
  input  logic [4:0]       memoryRD,
  input  logic             memory_memRead,
  input  logic             memory_memAccess,
  input  logic             dmemReady,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0]       MD_INIT  = 4'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e        state_q, state_d;
  logic [3:0]       md_count_q, md_count_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic freeze;
  logic load_use, br_exe, br_mem, md_stall, stall;
  logic ex_match, mem_match;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic dep_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    dep_match = (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  always_comb begin
    ex_match  = dep_match(executeRD, decodeRS, decodeRT, decodeUsesRT);
    mem_match = dep_match(memoryRD, decodeRS, decodeRT, decodeUsesRT);

    // Reset masks the occupancy at once so a pending mfhi is not held.
    mdBusy   = (state_q == MD_BUSY) && !rst;
    freeze   = memory_memAccess && !dmemReady;

    load_use = execute_memRead && ex_match;
    br_exe   = decodeBranch && execute_registerWrite && ex_match;
    br_mem   = decodeBranch && memory_memRead && mem_match;
    md_stall = mdBusy && (decodeStartMD || decodeReadsHiLo);
    stall    = load_use || br_exe || br_mem || md_stall;

    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    exmemWrite = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;

    if (rst) begin
      // defaults already describe the reset output values
    end else if (freeze) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
    end else if (stall) begin
      // Branch flush is dropped: the branch is re-evaluated once the stall clears.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else begin
      ifidFlush  = branchTaken;
    end
  end

  always_comb begin
    state_d        = state_q;
    md_count_d     = md_count_q;
    stall_cycles_d = stall_cycles_q;

    if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (decodeStartMD && !stall) begin
            state_d    = MD_BUSY;
            md_count_d = MD_INIT;
          end
        end
        MD_BUSY: begin
          if (md_count_q == 4'd1) begin
            state_d    = IDLE;
            md_count_d = 4'd0;
          end else begin
            md_count_d = md_count_q - 4'd1;
          end
        end
        default: begin
          state_d    = IDLE;
          md_count_d = 4'd0;
        end
      endcase
    end

    if (idexBubble && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      md_count_q     <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      md_count_q     <= md_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit

module tb_hazard_stall_unit;

  localparam int CNT_W = 16;

  // {pcWrite, ifidWrite, idexWrite, exmemWrite, idexBubble, ifidFlush, mdBusy}
  localparam logic [6:0] O_RUN    = 7'b1111000;
  localparam logic [6:0] O_STALL  = 7'b0011100;
  localparam logic [6:0] O_FLUSH  = 7'b1111010;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_MD     = 7'b0000001;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       decodeRS, decodeRT, executeRD, memoryRD;
  logic             decodeUsesRT, decodeBranch, decodeStartMD, decodeReadsHiLo;
  logic             execute_registerWrite, execute_memRead;
  logic             memory_memRead, memory_memAccess, dmemReady, branchTaken;
  logic             pcWrite, ifidWrite, idexWrite, exmemWrite;
  logic             idexBubble, ifidFlush, mdBusy;
  logic [CNT_W-1:0] stallCycles;
  logic [6:0]       outs;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign outs = {pcWrite, ifidWrite, idexWrite, exmemWrite, idexBubble, ifidFlush, mdBusy};

  hazard_stall_unit #(.MULDIV_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .decodeRS              (decodeRS),
    .decodeRT              (decodeRT),
    .decodeUsesRT          (decodeUsesRT),
    .decodeBranch          (decodeBranch),
    .decodeStartMD         (decodeStartMD),
    .decodeReadsHiLo       (decodeReadsHiLo),
    .executeRD             (executeRD),
    .execute_registerWrite (execute_registerWrite),
    .execute_memRead       (execute_memRead),
    .memoryRD              (memoryRD),
    .memory_memRead        (memory_memRead),
    .memory_memAccess      (memory_memAccess),
    .dmemReady             (dmemReady),
    .branchTaken           (branchTaken),
    .pcWrite               (pcWrite),
    .ifidWrite             (ifidWrite),
    .idexWrite             (idexWrite),
    .exmemWrite            (exmemWrite),
    .idexBubble            (idexBubble),
    .ifidFlush             (ifidFlush),
    .mdBusy                (mdBusy),
    .stallCycles           (stallCycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    decodeRS = 5'd0; decodeRT = 5'd0; decodeUsesRT = 1'b0; decodeBranch = 1'b0;
    decodeStartMD = 1'b0; decodeReadsHiLo = 1'b0;
    executeRD = 5'd0; execute_registerWrite = 1'b0; execute_memRead = 1'b0;
    memoryRD = 5'd0; memory_memRead = 1'b0; memory_memAccess = 1'b0;
    dmemReady = 1'b1; branchTaken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    #1 chk("rst_outs", 32'(outs), 32'(O_RUN));
    rst = 1'b0;
    #1 chk("rst_cnt", 32'(stallCycles), 32'd0);
  endtask

  task automatic set_load_use();
    execute_memRead = 1'b1; execute_registerWrite = 1'b1; executeRD = 5'd8; decodeRS = 5'd8;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // load-use: lw $t0 in EX, add reads rs=$t0 in ID
    set_load_use();
    #1 chk("lu_stall", 32'(outs), 32'(O_STALL));
    tick();
    clear_inputs();
    memoryRD = 5'd8; memory_memRead = 1'b1; memory_memAccess = 1'b1; decodeRS = 5'd8;
    #1 chk("lu_release", 32'(outs), 32'(O_RUN));
    chk("lu_cnt", 32'(stallCycles), 32'd1);

    // register 0 and an unused rt never match
    tick();
    clear_inputs();
    execute_memRead = 1'b1; executeRD = 5'd0; decodeRS = 5'd0;
    #1 chk("lu_r0", 32'(outs), 32'(O_RUN));
    executeRD = 5'd8; decodeRS = 5'd3; decodeRT = 5'd8; decodeUsesRT = 1'b0;
    #1 chk("lu_rt_unused", 32'(outs), 32'(O_RUN));
    decodeUsesRT = 1'b1;
    #1 chk("lu_rt_used", 32'(outs), 32'(O_STALL));

    // freeze beats stall and holds the counter
    tick();
    chk("cnt_before_frz", 32'(stallCycles), 32'd2);
    memory_memAccess = 1'b1; dmemReady = 1'b0;
    #1 chk("frz_over_stall", 32'(outs), 32'(O_FREEZE));
    tick();
    chk("frz_cnt_hold", 32'(stallCycles), 32'd2);

    // load to r9 then beq on r9: two bubbles, then the flush
    do_reset();
    execute_memRead = 1'b1; execute_registerWrite = 1'b1; executeRD = 5'd9;
    decodeBranch = 1'b1; decodeRS = 5'd9; branchTaken = 1'b1;
    #1 chk("br_ld_1", 32'(outs), 32'(O_STALL));
    tick();
    execute_memRead = 1'b0; execute_registerWrite = 1'b0; executeRD = 5'd0;
    memory_memRead = 1'b1; memory_memAccess = 1'b1; memoryRD = 5'd9;
    #1 chk("br_ld_2", 32'(outs), 32'(O_STALL));
    tick();
    memory_memRead = 1'b0; memory_memAccess = 1'b0; memoryRD = 5'd0;
    #1 chk("br_ld_flush", 32'(outs), 32'(O_FLUSH));
    chk("br_ld_cnt", 32'(stallCycles), 32'd2);

    // beq on an ALU result in EX: one bubble
    tick();
    clear_inputs();
    execute_registerWrite = 1'b1; executeRD = 5'd5;
    decodeBranch = 1'b1; decodeRS = 5'd1; decodeRT = 5'd5; decodeUsesRT = 1'b1;
    #1 chk("br_alu_1", 32'(outs), 32'(O_STALL));
    tick();
    execute_registerWrite = 1'b0; executeRD = 5'd0; memoryRD = 5'd5;
    #1 chk("br_alu_go", 32'(outs), 32'(O_RUN));
    chk("br_alu_cnt", 32'(stallCycles), 32'd3);

    // mult then mfhi, with two frozen cycles in the middle
    do_reset();
    decodeStartMD = 1'b1;
    #1 chk("md_issue", 32'(outs), 32'(O_RUN));
    tick();
    decodeStartMD = 1'b0; decodeReadsHiLo = 1'b1;
    #1 chk("md_c1", 32'(outs), 32'(O_STALL | O_MD));
    tick();
    memory_memAccess = 1'b1; dmemReady = 1'b0;
    #1 chk("md_frz1", 32'(outs), 32'(O_FREEZE | O_MD));
    tick();
    #1 chk("md_frz2", 32'(outs), 32'(O_FREEZE | O_MD));
    tick();
    memory_memAccess = 1'b0; dmemReady = 1'b1;
    #1 chk("md_c4", 32'(outs), 32'(O_STALL | O_MD));
    tick();
    decodeReadsHiLo = 1'b0; decodeStartMD = 1'b1;
    #1 chk("md_c5_new_md", 32'(outs), 32'(O_STALL | O_MD));
    tick();
    decodeStartMD = 1'b0; decodeReadsHiLo = 1'b1;
    #1 chk("md_c6", 32'(outs), 32'(O_STALL | O_MD));
    tick();
    #1 chk("md_done", 32'(outs), 32'(O_RUN));
    chk("md_cnt", 32'(stallCycles), 32'd4);

    // reset during MD_BUSY with mdCount=3
    do_reset();
    decodeStartMD = 1'b1;
    tick();
    decodeStartMD = 1'b0; decodeReadsHiLo = 1'b1;
    #1 chk("mdr_busy", 32'(outs), 32'(O_STALL | O_MD));
    tick();
    rst = 1'b1;
    #1 chk("mdr_forced", 32'(outs), 32'(O_RUN));
    tick();
    rst = 1'b0;
    #1 chk("mdr_idle", 32'(outs), 32'(O_RUN));
    chk("mdr_cnt", 32'(stallCycles), 32'd0);

    // saturation of the bubble counter
    do_reset();
    set_load_use();
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    #1 chk("sat_cnt", 32'(stallCycles), 32'hFFFF);
    chk("sat_outs", 32'(outs), 32'(O_STALL));
    tick();
    #1 chk("sat_hold", 32'(stallCycles), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
